// File: rtl/sonata_pkg.sv
// Shared constants and types for the Sonata pin conditioning blocks.
package sonata_pkg;

  localparam int unsigned IN_PIN_NUM           = 8;
  localparam int unsigned PIN_FILTER_CNT_WIDTH = 8;

  typedef logic [PIN_FILTER_CNT_WIDTH-1:0] pin_filter_cnt_t;

endpackage

// File: rtl/pin_filter_bit.sv
// Single-pin conditioner: 2-flop synchroniser, stable-count filter, edge pulses
// and (with SONATA_PIN_EVENT_EN) a sticky change flag with interrupt term.
module pin_filter_bit
  import sonata_pkg::*;
#(
  parameter int unsigned CntWidth   = PIN_FILTER_CNT_WIDTH,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pin_i,
  input  logic                filter_en_i,
  input  logic [CntWidth-1:0] filter_cycles_i,
  output logic                pin_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                event_o,
  input  logic                event_clr_i,
  input  logic                irq_en_i,
  output logic                irq_o
);

  logic                sync_q1;
  logic                sync_q2;
  logic [CntWidth-1:0] cnt_q;
  logic                differ;
  logic                take;

  // The >= lets a threshold lowered mid-count release the pending change at once.
  assign differ = (sync_q2 != pin_o);
  assign take   = differ && (!filter_en_i || (cnt_q >= filter_cycles_i));

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q1 <= ResetValue;
      sync_q2 <= ResetValue;
      pin_o   <= ResetValue;
      cnt_q   <= '0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_q1 <= pin_i;
      sync_q2 <= sync_q1;
      if (take || !differ) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
      if (take) begin
        pin_o <= sync_q2;
      end
      rise_o <= take &  sync_q2;
      fall_o <= take & ~sync_q2;
    end
  end

`ifdef SONATA_PIN_EVENT_EN
  // A new change outranks a clear landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      event_o <= 1'b0;
    end else if (take) begin
      event_o <= 1'b1;
    end else if (event_clr_i) begin
      event_o <= 1'b0;
    end
  end

  assign irq_o = event_o & irq_en_i;
`else
  logic unused_event_inputs;
  assign unused_event_inputs = event_clr_i ^ irq_en_i;

  assign event_o = 1'b0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: rtl/in_pin_filter.sv
// Conditions raw pad inputs ahead of the pinmux, one pin_filter_bit per pin.
// Sticky events and the interrupt exist only when SONATA_PIN_EVENT_EN is defined.
module in_pin_filter
  import sonata_pkg::*;
#(
  parameter int unsigned     Width      = IN_PIN_NUM,
  parameter int unsigned     CntWidth   = PIN_FILTER_CNT_WIDTH,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    pins_i,
  input  logic [Width-1:0]    filter_en_i,
  input  logic [CntWidth-1:0] filter_cycles_i,
  output logic [Width-1:0]    pins_o,
  output logic [Width-1:0]    rise_o,
  output logic [Width-1:0]    fall_o,
  output logic [Width-1:0]    event_o,
  input  logic [Width-1:0]    event_clr_i,
  input  logic [Width-1:0]    irq_en_i,
  output logic                irq_o
);

  logic [Width-1:0] irq_bits;

  for (genvar i = 0; i < Width; i++) begin : g_pin
    pin_filter_bit #(
      .CntWidth   (CntWidth),
      .ResetValue (ResetValue[i])
    ) u_bit (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .pin_i           (pins_i[i]),
      .filter_en_i     (filter_en_i[i]),
      .filter_cycles_i (filter_cycles_i),
      .pin_o           (pins_o[i]),
      .rise_o          (rise_o[i]),
      .fall_o          (fall_o[i]),
      .event_o         (event_o[i]),
      .event_clr_i     (event_clr_i[i]),
      .irq_en_i        (irq_en_i[i]),
      .irq_o           (irq_bits[i])
    );
  end

  assign irq_o = |irq_bits;

endmodule

// File: tb/tb_in_pin_filter.sv
// Self-checking bench for in_pin_filter: vector table, directed corner
// sequences and randomized traffic against a run-length reference model.
module tb_in_pin_filter;
  import sonata_pkg::*;

  localparam int W = IN_PIN_NUM;
`ifdef SONATA_PIN_EVENT_EN
  localparam bit EvBuilt = 1'b1;
`else
  localparam bit EvBuilt = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    pins = '0;
  logic [W-1:0]    fen = '0;
  pin_filter_cnt_t ncyc = '0;
  logic [W-1:0]    clr = '0;
  logic [W-1:0]    ien = '0;
  logic [W-1:0]    pins_o, rise_o, fall_o, event_o;
  logic            irq_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  in_pin_filter dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pins_i          (pins),
    .filter_en_i     (fen),
    .filter_cycles_i (ncyc),
    .pins_o          (pins_o),
    .rise_o          (rise_o),
    .fall_o          (fall_o),
    .event_o         (event_o),
    .event_clr_i     (clr),
    .irq_en_i        (ien),
    .irq_o           (irq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pins  = '0;
    clr   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: a pin flips once the trailing run of synchronised samples
  // that disagree with the output is longer than the threshold (or at once in bypass).
  logic [W-1:0] m_d1, m_d2, m_out, m_rise, m_fall, m_ev;
  logic         m_irq;
  bit           hist [W][$];

  task automatic model_step();
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_ev = '0;
      for (int i = 0; i < W; i++) hist[i].delete();
    end else begin
      for (int i = 0; i < W; i++) begin
        bit cur;
        bit upd;
        int run;
        cur = m_d2[i];
        hist[i].push_back(cur);
        if (hist[i].size() > 300) void'(hist[i].pop_front());
        run = 0;
        for (int t = hist[i].size() - 1; t >= 0 && hist[i][t] != m_out[i]; t--) run++;
        upd = (run > 0) && (!fen[i] || run >= int'(ncyc) + 1);
        m_rise[i] = upd && cur;
        m_fall[i] = upd && !cur;
        m_ev[i]   = EvBuilt && (upd || (m_ev[i] && !clr[i]));
        if (upd) m_out[i] = cur;
      end
      m_d2 = m_d1;
      m_d1 = pins;
    end
    m_irq = |(m_ev & ien);
  endtask

  typedef struct {
    logic [W-1:0] pins, clr, ien;
    logic [W-1:0] e_pins, e_rise, e_fall, e_ev;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Bypass table: pin 0 pulse, pin 3 rise, clears and irq enables.
    tbl[0] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    tbl[3] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    tbl[4] = '{8'h09, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    tbl[5] = '{8'h08, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    tbl[6] = '{8'h08, 8'h00, 8'h01, 8'h09, 8'h08, 8'h00, 8'h09};
    tbl[7] = '{8'h08, 8'h00, 8'h01, 8'h08, 8'h00, 8'h01, 8'h09};
    tbl[8] = '{8'h08, 8'h01, 8'h01, 8'h08, 8'h00, 8'h00, 8'h08};
    tbl[9] = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h08};

    @(negedge clk);

    // Reset with pads at the reset level: nothing moves for 20 cycles.
    do_reset();
    for (int j = 0; j < 20; j++) begin
      tick();
      check("reset_quiet", 64'({pins_o, rise_o, fall_o, event_o, irq_o}), 64'(0));
    end

    // Bypass vector table.
    fen = '0;
    for (int v = 0; v < 10; v++) begin
      pins = tbl[v].pins;
      clr  = tbl[v].clr;
      ien  = tbl[v].ien;
      tick();
      check($sformatf("tbl%0d_pins", v), 64'(pins_o), 64'(tbl[v].e_pins));
      check($sformatf("tbl%0d_rise", v), 64'(rise_o), 64'(tbl[v].e_rise));
      check($sformatf("tbl%0d_fall", v), 64'(fall_o), 64'(tbl[v].e_fall));
      check($sformatf("tbl%0d_ev", v), 64'(event_o), 64'(EvBuilt ? tbl[v].e_ev : 8'h00));
      check($sformatf("tbl%0d_irq", v), 64'(irq_o),
            64'(EvBuilt && (|(tbl[v].e_ev & tbl[v].ien))));
    end
    clr = '0;

    // Filter N=4: a 4-cycle glitch on pin 1 must be swallowed.
    do_reset();
    fen  = 8'h02;
    ncyc = 8'd4;
    ien  = 8'h02;
    pins[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("glitch_hi", 64'({pins_o[1], rise_o[1], event_o[1], irq_o}), 64'(0));
    end
    pins[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      check("glitch_lo", 64'({pins_o[1], rise_o[1], event_o[1], irq_o}), 64'(0));
    end

    // Filter N=4: a held change appears at edge k+6 with a single rise pulse.
    pins[1] = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      tick();
      check($sformatf("hold_pin_k%0d", j), 64'(pins_o[1]), 64'(j >= 6));
      check($sformatf("hold_rise_k%0d", j), 64'(rise_o[1]), 64'(j == 6));
      check($sformatf("hold_ev_k%0d", j), 64'(event_o[1]), 64'(EvBuilt && j >= 6));
      check($sformatf("hold_irq_k%0d", j), 64'(irq_o), 64'(EvBuilt && j >= 6));
    end

    // Clear coinciding with a new fall loses; a later isolated clear wins.
    pins[1] = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      clr[1] = (j == 6);
      tick();
      check($sformatf("fall_pin_k%0d", j), 64'(pins_o[1]), 64'(j < 6));
      check($sformatf("fall_pulse_k%0d", j), 64'(fall_o[1]), 64'(j == 6));
    end
    check("clr_vs_set_ev", 64'(event_o[1]), 64'(EvBuilt));
    clr = '0;
    tick();
    check("ev_held", 64'({fall_o[1], event_o[1], irq_o}), 64'({1'b0, EvBuilt, EvBuilt}));
    clr[1] = 1'b1;
    tick();
    clr = '0;
    check("iso_clr", 64'({event_o[1], irq_o}), 64'(0));

    // N=200, count reaches 100, then the threshold drops to 50.
    do_reset();
    fen  = 8'h04;
    ncyc = 8'd200;
    pins[2] = 1'b1;
    for (int j = 0; j <= 101; j++) tick();
    check("long_pending", 64'(pins_o[2]), 64'(0));
    ncyc = 8'd50;
    tick();
    check("lowered_pin", 64'(pins_o[2]), 64'(1));
    check("lowered_rise", 64'(rise_o[2]), 64'(1));
    pins[2] = 1'b0;
    for (int j = 0; j <= 52; j++) begin
      tick();
      if (j >= 50) check($sformatf("n50_fall_k%0d", j), 64'(pins_o[2]), 64'(j < 52));
    end

    // Randomized traffic against the reference model.
    for (int ph = 0; ph < 8; ph++) begin
      int rate;
      case (ph % 4)
        0:       ncyc = 8'd0;
        1:       ncyc = 8'd3;
        2:       ncyc = pin_filter_cnt_t'($urandom_range(1, 8));
        default: ncyc = pin_filter_cnt_t'($urandom_range(0, 20));
      endcase
      fen  = W'($urandom);
      rate = int'($urandom_range(1, 12));
      for (int c = 0; c < 500; c++) begin
        rst_n = !(ph == 0 && c == 0) && ($urandom_range(0, 299) != 0);
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, rate - 1) == 0) pins[i] = ~pins[i];
        clr = W'($urandom & $urandom & $urandom);
        ien = W'($urandom);
        if ($urandom_range(0, 49) == 0) begin
          int k;
          k = int'($urandom_range(0, W - 1));
          fen[k] = ~fen[k];
        end
        if ($urandom_range(0, 99) == 0) ncyc = pin_filter_cnt_t'($urandom_range(0, 10));
        model_step();
        tick();
        check("rand", 64'({pins_o, rise_o, fall_o, event_o, irq_o}),
              64'({m_out, m_rise, m_fall, m_ev, m_irq}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
